// File: rtl/channel_fifo.sv
// channel_fifo: in-order elastic buffer between the producer's en/rdy channel and the downstream consumer.
// Latency: a word pushed on edge N is presented with channel_out_en=1 after that edge; there is no fall-through when empty.
// Backpressure: channel_in_rdy drops while full, with no bypass even when a pop happens in the same cycle; channel_out_rdy is ignored while empty.
// Optional build macro CHANNEL_FIFO_STATS_EN adds the level and peak occupancy outputs.
module channel_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      channel_in_data,
    input  logic                  channel_in_en,
    output logic                  channel_in_rdy,
    output logic [WIDTH-1:0]      channel_out_data,
    output logic                  channel_out_en,
    input  logic                  channel_out_rdy
`ifdef CHANNEL_FIFO_STATS_EN
    ,
    output logic [DEPTH_LOG2:0]   level,
    output logic [DEPTH_LOG2:0]   peak
`endif
);

    localparam int                  DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic                  in_rdy_q;
    logic                  out_en_q;
    logic                  push;
    logic                  pop;

    // Handshakes only ever look at registered flags, so no input reaches the opposite side's outputs.
    assign push = channel_in_en && in_rdy_q;
    assign pop  = out_en_q && channel_out_rdy;

    assign channel_in_rdy   = in_rdy_q;
    assign channel_out_en   = out_en_q;
    assign channel_out_data = mem[rd_ptr];

    // Next occupancy: a simultaneous push and pop cancel out.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // Pointers, occupancy and the registered rdy/en flags; both flags stay low while reset is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_rdy_q <= 1'b0;
            out_en_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count    <= count_nxt;
            in_rdy_q <= (count_nxt != DEPTH_C);
            out_en_q <= (count_nxt != '0);
        end
    end

    // Storage array, cleared on reset so an empty FIFO shows 0 until the first write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= channel_in_data;
        end
    end

`ifdef CHANNEL_FIFO_STATS_EN
    logic [DEPTH_LOG2:0] peak_q;

    // High-water mark follows count upward on the same edge and only falls on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_q <= '0;
        end else if (count_nxt > peak_q) begin
            peak_q <= count_nxt;
        end
    end

    assign level = count;
    assign peak  = peak_q;
`endif

endmodule

// File: tb/tb_channel_fifo.sv
// Bench for channel_fifo: directed stimulus with a scoreboard queue of expected output words.
// A monitor on the falling edge checks en/rdy against the scoreboard occupancy and compares every popped word.
module tb_channel_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] channel_in_data;
    logic             channel_in_en;
    logic             channel_in_rdy;
    logic [WIDTH-1:0] channel_out_data;
    logic             channel_out_en;
    logic             channel_out_rdy;
`ifdef CHANNEL_FIFO_STATS_EN
    logic [2:0]       level;
    logic [2:0]       peak;
`endif

    channel_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .channel_in_data  (channel_in_data),
        .channel_in_en    (channel_in_en),
        .channel_in_rdy   (channel_in_rdy),
        .channel_out_data (channel_out_data),
        .channel_out_en   (channel_out_en),
        .channel_out_rdy  (channel_out_rdy)
`ifdef CHANNEL_FIFO_STATS_EN
        ,
        .level            (level),
        .peak             (peak)
`endif
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic        live = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: occupancy flags against the model, then pop and compare the head word.
    always @(negedge clk) begin
        if (rst && live) begin
            check("out_en_vs_model", 32'(channel_out_en), 32'(exp_q.size() != 0));
            check("in_rdy_vs_model", 32'(channel_in_rdy), 32'(exp_q.size() != DEPTH));
            if (channel_out_en && channel_out_rdy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h, expected none", channel_out_data);
                end else begin
                    check("out_data", channel_out_data, exp_q.pop_front());
                end
            end
        end
    end

    // One cycle of stimulus: inputs applied just after the rising edge, acceptance judged at the falling edge.
    task automatic cyc(input logic en, input logic [31:0] d, input logic ordy, output logic acc);
        channel_in_en   = en;
        channel_in_data = d;
        channel_out_rdy = ordy;
        @(negedge clk);
        acc = en && channel_in_rdy;
        @(posedge clk);
        if (acc) exp_q.push_back(d);
        #1;
    endtask

    task automatic drain();
        logic acc;
        int   budget = 50;
        while (exp_q.size() != 0 && budget > 0) begin
            cyc(1'b0, 32'h0, 1'b1, acc);
            budget--;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        channel_out_rdy = 1'b0;
    endtask

    initial begin
        logic acc;
        int   sent;
        int   c;

        rst = 1'b0;
        channel_in_en = 1'b0;
        channel_in_data = '0;
        channel_out_rdy = 1'b0;

        // Reset held with random inputs: everything stays quiet.
        for (int i = 0; i < 5; i++) begin
            channel_in_en   = 1'($urandom);
            channel_in_data = $urandom;
            channel_out_rdy = 1'($urandom);
            @(negedge clk);
            check("rst_in_rdy", 32'(channel_in_rdy), 32'd0);
            check("rst_out_en", 32'(channel_out_en), 32'd0);
            check("rst_out_data", channel_out_data, 32'd0);
            @(posedge clk);
            #1;
        end
        channel_in_en = 1'b0;
        channel_out_rdy = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        live = 1'b1;
        check("post_rst_in_rdy", 32'(channel_in_rdy), 32'd1);

        // Single word
        cyc(1'b1, 32'd123, 1'b0, acc);
        check("single_acc", 32'(acc), 32'd1);
        check("single_en", 32'(channel_out_en), 32'd1);
        check("single_data", channel_out_data, 32'd123);
        cyc(1'b0, 32'h0, 1'b1, acc);
        check("single_en_after", 32'(channel_out_en), 32'd0);
`ifdef CHANNEL_FIFO_STATS_EN
        check("single_level", 32'(level), 32'd0);
`endif

        // Fill and stall
        for (int i = 10; i <= 13; i++) begin
            cyc(1'b1, 32'(i), 1'b0, acc);
            check("fill_acc", 32'(acc), 32'd1);
        end
        check("full_in_rdy", 32'(channel_in_rdy), 32'd0);
`ifdef CHANNEL_FIFO_STATS_EN
        check("full_level", 32'(level), 32'd4);
        check("full_peak", 32'(peak), 32'd4);
`endif
        cyc(1'b1, 32'd14, 1'b0, acc);
        check("full_reject", 32'(acc), 32'd0);
        cyc(1'b1, 32'd14, 1'b1, acc);
        check("full_no_bypass", 32'(acc), 32'd0);
        cyc(1'b1, 32'd14, 1'b0, acc);
        check("after_pop_acc", 32'(acc), 32'd1);
        channel_in_en = 1'b0;
        drain();
`ifdef CHANNEL_FIFO_STATS_EN
        check("drain_peak", 32'(peak), 32'd4);
        check("drain_level", 32'(level), 32'd0);
`endif

        // Streaming at constant occupancy 2
        cyc(1'b1, 32'd1, 1'b0, acc);
        cyc(1'b1, 32'd2, 1'b0, acc);
        for (int i = 3; i <= 20; i++) begin
            cyc(1'b1, 32'(i), 1'b1, acc);
            check("stream_acc", 32'(acc), 32'd1);
`ifdef CHANNEL_FIFO_STATS_EN
            check("stream_level", 32'(level), 32'd2);
`endif
        end
        channel_in_en = 1'b0;
        drain();

        // Wrap-around with alternating consumer stalls
        sent = 1;
        c = 0;
        while (sent <= 10 && c < 100) begin
            cyc(1'b1, 32'(sent), c[0], acc);
            if (acc) sent++;
            c++;
        end
        check("wrap_all_sent", 32'(sent), 32'd11);
        channel_in_en = 1'b0;
        drain();

        // Reset mid-stream
        cyc(1'b1, 32'h31, 1'b0, acc);
        cyc(1'b1, 32'h32, 1'b0, acc);
        cyc(1'b1, 32'h33, 1'b0, acc);
        channel_in_en = 1'b0;
        live = 1'b0;
        exp_q.delete();
        rst = 1'b0;
        #1;
        check("midrst_out_en", 32'(channel_out_en), 32'd0);
        check("midrst_in_rdy", 32'(channel_in_rdy), 32'd0);
        check("midrst_data", channel_out_data, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        live = 1'b1;
        check("midrst_rdy_back", 32'(channel_in_rdy), 32'd1);
        cyc(1'b1, 32'd77, 1'b0, acc);
        check("midrst_77_data", channel_out_data, 32'd77);
        channel_in_en = 1'b0;
        drain();

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
